// File: rtl/hazard_scoreboard_ctrl_if.sv
// Signal bundle between the ID/EX pipeline stages and the hazard scoreboard controller.
// The pipeline side is the master; the controller is the slave.
interface hazard_scoreboard_ctrl_if #(
    parameter int unsigned PERF_W = 16
);
    logic              id_valid;
    logic [6:0]        opcode_id;
    logic [6:0]        id_funct7;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              ex_valid;
    logic              ex_reg_write;
    logic [4:0]        ex_rd;
    logic              ex_load_inst;
    logic              ex_md_inst;
    logic              modify_pc_ex;
    logic              pc_en;
    logic              if_id_en;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output id_valid, opcode_id, id_funct7, id_rs1, id_rs2,
               ex_valid, ex_reg_write, ex_rd, ex_load_inst, ex_md_inst, modify_pc_ex,
        input  pc_en, if_id_en, if_id_flush, id_ex_flush, md_busy, stall_cycles
    );

    modport slave (
        input  id_valid, opcode_id, id_funct7, id_rs1, id_rs2,
               ex_valid, ex_reg_write, ex_rd, ex_load_inst, ex_md_inst, modify_pc_ex,
        output pc_en, if_id_en, if_id_flush, id_ex_flush, md_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_scoreboard_ctrl.sv
// ID-stage hazard controller: per-register countdown scoreboard for loads and mul/div results,
// structural mul/div occupancy, redirect/stall steering and a saturating stall counter.
module hazard_scoreboard_ctrl #(
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned MD_LAT   = 4,
    parameter bit          FLUSH_IF = 1'b1,
    parameter int unsigned PERF_W   = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    hazard_scoreboard_ctrl_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] MD_INIT   = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Entry r counts cycles until x[r] is forwardable; x0 has no entry.
    logic [31:1][CNT_W-1:0] cnt;
    logic [CNT_W-1:0]       md_cnt;
    logic [PERF_W-1:0]      stall_q;

    logic        rs1_used;
    logic        rs2_used;
    logic        id_md;
    logic        ex_live;
    logic [31:0] busy_vec;
    logic        pend_rs1;
    logic        pend_rs2;
    logic        md_block;
    logic        hazard;
    logic        stall_inc;

    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;

    // Source-operand usage by instruction format; unknown opcodes read nothing.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (bus.opcode_id)
            OPC_R, OPC_STORE, OPC_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_I, OPC_LOAD, OPC_JALR: rs1_used = 1'b1;
            default: ;
        endcase
    end

    assign id_md   = (bus.opcode_id == OPC_R) && (bus.id_funct7 == F7_MULDIV);
    assign ex_live = bus.ex_valid && bus.ex_reg_write
                  && (bus.ex_load_inst || bus.ex_md_inst) && (bus.ex_rd != 5'd0);

    always_comb begin
        busy_vec[0] = 1'b0;
        for (int r = 1; r < 32; r++) begin
            busy_vec[r] = (cnt[r] != '0);
        end
    end

    // The EX compare covers the cycle in which the producer has not yet loaded its counter.
    assign pend_rs1 = (bus.id_rs1 != 5'd0)
                   && (busy_vec[bus.id_rs1] || (ex_live && (bus.ex_rd == bus.id_rs1)));
    assign pend_rs2 = (bus.id_rs2 != 5'd0)
                   && (busy_vec[bus.id_rs2] || (ex_live && (bus.ex_rd == bus.id_rs2)));
    assign md_block = id_md && ((md_cnt != '0) || (bus.ex_valid && bus.ex_md_inst));

    assign hazard    = bus.id_valid && ((rs1_used && pend_rs1) || (rs2_used && pend_rs2) || md_block);
    assign stall_inc = hazard && !bus.modify_pc_ex;

    // Redirect beats stall: the ID instruction is on the wrong path anyway.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (!rst_n) begin
            pc_en = 1'b1;
        end else if (bus.modify_pc_ex) begin
            if_id_flush = FLUSH_IF;
            id_ex_flush = 1'b1;
        end else if (hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // NOTE: the scoreboard is a flop array, not a RAM, so it takes the async reset; a reset must discard every pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                // NOTE: sequential state uses <= so every entry sees the pre-edge values of its neighbours.
                if (ex_live && (bus.ex_rd == 5'(r))) begin
                    cnt[r] <= bus.ex_load_inst ? LOAD_INIT : MD_INIT;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

    // Occupancy is tracked for every mul/div, including those writing x0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (bus.ex_valid && bus.ex_md_inst) begin
            md_cnt <= MD_INIT;
        end else if (md_cnt != '0) begin
            md_cnt <= md_cnt - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (stall_inc && (stall_q != '1)) begin
            stall_q <= stall_q + PERF_W'(1);
        end
    end

    assign bus.pc_en        = pc_en;
    assign bus.if_id_en     = if_id_en;
    assign bus.if_id_flush  = if_id_flush;
    assign bus.id_ex_flush  = id_ex_flush;
    assign bus.md_busy      = (md_cnt != '0);
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: two differently parameterised instances share one stimulus stream
// and are compared against a timestamp-based reference model.
module tb_hazard_scoreboard_ctrl;
    localparam logic [6:0] R_T = 7'b0110011, I_T = 7'b0010011, LD_T = 7'b0000011;
    localparam logic [6:0] ST_T = 7'b0100011, BR_T = 7'b1100011, JALR_T = 7'b1100111;
    localparam logic [6:0] JAL_T = 7'b1101111, LUI_T = 7'b0110111, BAD_T = 7'b1111111;

    // Instance 0: LOAD_LAT=3 MD_LAT=4 FLUSH_IF=1 PERF_W=16; instance 1: LOAD_LAT=1 MD_LAT=2 FLUSH_IF=0 PERF_W=4.
    int ll_p [2] = '{3, 1};
    int ml_p [2] = '{4, 2};
    int fi_p [2] = '{1, 0};
    int max_p[2] = '{65535, 15};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_ctrl_if #(.PERF_W(16)) bus0();
    hazard_scoreboard_ctrl_if #(.PERF_W(4))  bus1();

    hazard_scoreboard_ctrl #(.LOAD_LAT(3), .MD_LAT(4), .FLUSH_IF(1'b1), .PERF_W(16))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    hazard_scoreboard_ctrl #(.LOAD_LAT(1), .MD_LAT(2), .FLUSH_IF(1'b0), .PERF_W(4))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    // Current stimulus
    logic       iv, ev, wr, ld, md, mpc;
    logic [6:0] op, f7;
    logic [4:0] r1, r2, rd;

    // Reference model: cycle at which each register / the mul-div unit becomes free.
    int cyc;
    int ready[2][32];
    int md_free[2];
    int stall_m[2];

    int errors = 0;
    int checks = 0;
    logic obs_pc[2];
    logic obs_mb[2];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic uses1(input logic [6:0] o);
        return o inside {R_T, I_T, LD_T, ST_T, BR_T, JALR_T};
    endfunction

    function automatic logic uses2(input logic [6:0] o);
        return o inside {R_T, ST_T, BR_T};
    endfunction

    function automatic logic ex_live_m();
        return ev && wr && (ld || md) && rd != 0;
    endfunction

    function automatic logic pend_m(input int k, input logic [4:0] r);
        return r != 0 && (cyc < ready[k][r] || (ex_live_m() && rd == r));
    endfunction

    function automatic logic hazard_m(input int k);
        logic is_md;
        is_md = (op == R_T) && (f7 == 7'b0000001);
        return iv && ((uses1(op) && pend_m(k, r1)) || (uses2(op) && pend_m(k, r2))
                      || (is_md && (cyc < md_free[k] || (ev && md))));
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) ready[k][r] = 0;
            md_free[k] = 0;
            stall_m[k] = 0;
        end
    endtask

    task automatic set_in(input logic i_v, input logic [6:0] i_op, input logic [6:0] i_f7,
                          input logic [4:0] i_r1, input logic [4:0] i_r2,
                          input logic e_v, input logic e_wr, input logic [4:0] e_rd,
                          input logic e_ld, input logic e_md, input logic m_pc);
        iv = i_v; op = i_op; f7 = i_f7; r1 = i_r1; r2 = i_r2;
        ev = e_v; wr = e_wr; rd = e_rd; ld = e_ld; md = e_md; mpc = m_pc;
    endtask

    task automatic bubble_ex();
        ev = 1'b0; wr = 1'b0; rd = 5'd0; ld = 1'b0; md = 1'b0; mpc = 1'b0;
    endtask

    task automatic drive();
        bus0.id_valid = iv; bus0.opcode_id = op; bus0.id_funct7 = f7; bus0.id_rs1 = r1; bus0.id_rs2 = r2;
        bus0.ex_valid = ev; bus0.ex_reg_write = wr; bus0.ex_rd = rd; bus0.ex_load_inst = ld;
        bus0.ex_md_inst = md; bus0.modify_pc_ex = mpc;
        bus1.id_valid = iv; bus1.opcode_id = op; bus1.id_funct7 = f7; bus1.id_rs1 = r1; bus1.id_rs2 = r2;
        bus1.ex_valid = ev; bus1.ex_reg_write = wr; bus1.ex_rd = rd; bus1.ex_load_inst = ld;
        bus1.ex_md_inst = md; bus1.modify_pc_ex = mpc;
    endtask

    // One clock: drive, check combinational outputs mid-cycle, then advance the model at the edge.
    task automatic step(input logic rst_v);
        logic hz;
        logic e_pe, e_ie, e_if, e_ef, e_mb;
        logic o_pe, o_ie, o_if, o_ef, o_mb;
        int   o_sc;
        @(negedge clk);
        rst_n = rst_v;
        drive();
        #1;
        if (!rst_n) clear_model();
        for (int k = 0; k < 2; k++) begin
            hz = hazard_m(k);
            e_pe = 1'b1; e_ie = 1'b1; e_if = 1'b0; e_ef = 1'b0;
            e_mb = rst_n && (cyc < md_free[k]);
            if (rst_n && mpc) begin
                e_if = (fi_p[k] != 0); e_ef = 1'b1;
            end else if (rst_n && hz) begin
                e_pe = 1'b0; e_ie = 1'b0; e_ef = 1'b1;
            end
            if (k == 0) begin
                o_pe = bus0.pc_en; o_ie = bus0.if_id_en; o_if = bus0.if_id_flush;
                o_ef = bus0.id_ex_flush; o_mb = bus0.md_busy; o_sc = int'(bus0.stall_cycles);
            end else begin
                o_pe = bus1.pc_en; o_ie = bus1.if_id_en; o_if = bus1.if_id_flush;
                o_ef = bus1.id_ex_flush; o_mb = bus1.md_busy; o_sc = int'(bus1.stall_cycles);
            end
            obs_pc[k] = o_pe;
            obs_mb[k] = o_mb;
            chk($sformatf("i%0d.pc_en", k), int'(o_pe), int'(e_pe));
            chk($sformatf("i%0d.if_id_en", k), int'(o_ie), int'(e_ie));
            chk($sformatf("i%0d.if_id_flush", k), int'(o_if), int'(e_if));
            chk($sformatf("i%0d.id_ex_flush", k), int'(o_ef), int'(e_ef));
            chk($sformatf("i%0d.md_busy", k), int'(o_mb), int'(e_mb));
            chk($sformatf("i%0d.stall_cycles", k), o_sc, stall_m[k]);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                for (int r = 0; r < 32; r++) ready[k][r] = 0;
                md_free[k] = 0;
                stall_m[k] = 0;
            end else begin
                if (hazard_m(k) && !mpc && stall_m[k] < max_p[k]) stall_m[k]++;
                if (ex_live_m()) ready[k][rd] = cyc + (ld ? ll_p[k] : ml_p[k]);
                if (ev && md) md_free[k] = cyc + ml_p[k];
            end
        end
        cyc++;
    endtask

    // Holds the current ID instruction with bubbles in EX and counts stalled / md-busy cycles.
    task automatic hold_and_count(input int n, output int st0, output int st1, output int mb0, output int mb1);
        st0 = 0; st1 = 0; mb0 = 0; mb1 = 0;
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            if (!obs_pc[0]) st0++;
            if (!obs_pc[1]) st1++;
            if (obs_mb[0]) mb0++;
            if (obs_mb[1]) mb1++;
            bubble_ex();
        end
    endtask

    task automatic idle(input int n);
        set_in(1'b0, I_T, 7'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (n) step(1'b1);
    endtask

    initial begin
        int st0, st1, mb0, mb1;
        cyc = 0;
        clear_model();

        // Reset state with inputs that would otherwise stall and redirect
        set_in(1'b1, R_T, 7'd0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        step(1'b0);
        step(1'b0);
        idle(2);

        // Load-use: lw x5 in EX, add x6,x5,x7 in ID
        set_in(1'b1, R_T, 7'd0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        hold_and_count(6, st0, st1, mb0, mb1);
        chk("loaduse_stalls_lat3", st0, 3);
        chk("loaduse_stalls_lat1", st1, 1);
        chk("loaduse_stall_cnt_lat3", int'(bus0.stall_cycles), 3);
        chk("loaduse_stall_cnt_lat1", int'(bus1.stall_cycles), 1);
        idle(4);

        // x0 destination never stalls; unused rs2 field never stalls
        set_in(1'b1, R_T, 7'd0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1);
        chk("x0_load_no_stall", int'(obs_pc[0]), 1);
        set_in(1'b1, I_T, 7'd0, 5'd2, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step(1'b1);
        chk("addi_rs2_field_no_stall", int'(obs_pc[0]), 1);
        idle(5);

        // Structural: mul x3 in EX, independent mul x8 in ID
        set_in(1'b1, R_T, 7'b0000001, 5'd9, 5'd10, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        hold_and_count(7, st0, st1, mb0, mb1);
        chk("md_struct_stalls_lat4", st0, 4);
        chk("md_busy_cycles_lat4", mb0, 3);
        chk("md_struct_stalls_lat2", st1, 2);
        chk("md_busy_cycles_lat2", mb1, 1);
        idle(2);

        // Data: mul x3 in EX, dependent add x4,x3,x1 in ID
        set_in(1'b1, R_T, 7'd0, 5'd3, 5'd1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        hold_and_count(7, st0, st1, mb0, mb1);
        chk("md_data_stalls_lat4", st0, 4);
        chk("md_data_stalls_lat2", st1, 2);
        idle(2);

        // Redirect in the same cycle as a load-use hazard
        set_in(1'b1, R_T, 7'd0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        step(1'b1);
        chk("redirect_if_id_flush_i0", int'(bus0.if_id_flush), 1);
        chk("redirect_pc_en_i0", int'(bus0.pc_en), 1);
        idle(4);

        // Reset during a mul/div countdown discards it
        set_in(1'b1, I_T, 7'd0, 5'd1, 5'd0, 1'b1, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0);
        step(1'b1);
        set_in(1'b1, R_T, 7'd0, 5'd3, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0);
        chk("reset_md_busy", int'(bus0.md_busy), 0);
        step(1'b0);
        step(1'b1);
        chk("post_reset_no_stall", int'(obs_pc[0]), 1);
        chk("post_reset_stall_cnt", int'(bus0.stall_cycles), 0);

        // Saturation: back-to-back structural stalls
        set_in(1'b1, R_T, 7'b0000001, 5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b1);
        idle(1);
        chk("stall_cnt_saturated_w4", int'(bus1.stall_cycles), 15);
        chk("stall_cnt_unsaturated_w16", int'(bus0.stall_cycles), 20);

        // Randomised traffic, with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops [9];
            int kind;
            ops = '{R_T, I_T, LD_T, ST_T, BR_T, JALR_T, JAL_T, LUI_T, BAD_T};
            iv = ($urandom_range(0, 7) != 0);
            op = ops[$urandom_range(0, 8)];
            f7 = ($urandom_range(0, 1) != 0) ? 7'b0000001 : 7'($urandom_range(0, 127));
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            ev = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 4) != 0);
            rd = 5'($urandom_range(0, 7));
            kind = $urandom_range(0, 3);
            ld = (kind == 0);
            md = (kind == 1);
            mpc = ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 99) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
